ps2_keyboard_rx: RTL

- Input-side counterpart to the 7-segment output path. Receives PS/2 keyboard frames from the NVBoard keyboard pins and checks each frame.
- Buffers valid scancodes in a small show-ahead FIFO for the core or debug logic to consume.
- Consumers typically feed the popped byte onward to the segment display.
- Single clock domain; PS/2 pins are treated as asynchronous and synchronised internally.

---
 rtl/ps2_keyboard_rx.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: synchronises the pins, frames and checks each scancode, and queues good
// bytes in a show-ahead FIFO. Define PS2_KEYSTATE_EN to build the make/break key-state tracker.
module ps2_keyboard_rx #(
    parameter int unsigned FIFO_DEPTH     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       rd_en,
    input  logic       clr_ovf,
    output logic [7:0] data,
    output logic       valid,
    output logic       overflow,
    output logic       frame_err,
    output logic [7:0] key_code,
    output logic       key_down
);

    localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = PW + 1;
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [0:0] {StIdle, StRecv} state_e;

    logic [2:0]    clk_sync_q, clk_sync_d;
    logic [2:0]    dat_sync_q, dat_sync_d;
    state_e        state_q, state_d;
    logic [3:0]    bit_cnt_q, bit_cnt_d;
    logic [8:0]    shift_q, shift_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          frame_err_q, frame_err_d;
    logic          fall, bit_in, good_frame;
    logic [7:0]    rx_byte;

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [7:0]    mem_d [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ovf_q, ovf_d;
    logic          full, push, pop;

    // Reset to 1 so releasing reset never looks like a falling edge.
    assign clk_sync_d = {clk_sync_q[1:0], ps2_clk};
    assign dat_sync_d = {dat_sync_q[1:0], ps2_data};
    assign fall       = clk_sync_q[2] & ~clk_sync_q[1];
    assign bit_in     = dat_sync_q[2];
    assign rx_byte    = shift_q[7:0];

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        tmo_d       = tmo_q;
        frame_err_d = 1'b0;
        good_frame  = 1'b0;
        unique case (state_q)
            StIdle: begin
                tmo_d     = '0;
                bit_cnt_d = '0;
                if (fall && !bit_in) begin
                    state_d   = StRecv;
                    bit_cnt_d = 4'd1;
                end
            end
            StRecv: begin
                if (fall) begin
                    tmo_d     = '0;
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'd10) begin
                        // Incoming bit is the stop bit; shift_q holds d0..d7 and parity.
                        state_d   = StIdle;
                        bit_cnt_d = '0;
                        if (bit_in && (^shift_q)) begin
                            good_frame = 1'b1;
                        end else begin
                            frame_err_d = 1'b1;
                        end
                    end else begin
                        shift_d = {bit_in, shift_q[8:1]};
                    end
                end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    state_d     = StIdle;
                    bit_cnt_d   = '0;
                    tmo_d       = '0;
                    frame_err_d = 1'b1;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign full  = (cnt_q == CW'(FIFO_DEPTH));
    assign pop   = rd_en && (cnt_q != '0);
    assign push  = good_frame && (!full || pop);
    assign valid = (cnt_q != '0);
    assign data  = valid ? mem_q[rd_ptr_q] : 8'h00;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        ovf_d    = ovf_q;
        if (push) begin
            mem_d[wr_ptr_q] = rx_byte;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        if (push && !pop) begin
            cnt_d = cnt_q + CW'(1);
        end else if (pop && !push) begin
            cnt_d = cnt_q - CW'(1);
        end
        // A drop in the same cycle as a clear keeps the flag set.
        if (good_frame && full && !pop) begin
            ovf_d = 1'b1;
        end else if (clr_ovf) begin
            ovf_d = 1'b0;
        end
    end

    assign overflow  = ovf_q;
    assign frame_err = frame_err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_sync_q  <= 3'b111;
            dat_sync_q  <= 3'b111;
            state_q     <= StIdle;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            tmo_q       <= '0;
            frame_err_q <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                mem_q[i] <= 8'h00;
            end
        end else begin
            clk_sync_q  <= clk_sync_d;
            dat_sync_q  <= dat_sync_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            tmo_q       <= tmo_d;
            frame_err_q <= frame_err_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            mem_q       <= mem_d;
        end
    end

`ifdef PS2_KEYSTATE_EN
    logic       brk_q, brk_d;
    logic [7:0] key_code_q, key_code_d;
    logic       key_down_q, key_down_d;

    // Sees every good byte, even ones the full FIFO drops.
    always_comb begin
        brk_d      = brk_q;
        key_code_d = key_code_q;
        key_down_d = key_down_q;
        if (good_frame) begin
            if (rx_byte == 8'hF0) begin
                brk_d = 1'b1;
            end else if (rx_byte != 8'hE0) begin
                key_code_d = rx_byte;
                key_down_d = ~brk_q;
                brk_d      = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            brk_q      <= 1'b0;
            key_code_q <= 8'h00;
            key_down_q <= 1'b0;
        end else begin
            brk_q      <= brk_d;
            key_code_q <= key_code_d;
            key_down_q <= key_down_d;
        end
    end

    assign key_code = key_code_q;
    assign key_down = key_down_q;
`else
    assign key_code = 8'h00;
    assign key_down = 1'b0;
`endif

endmodule
